// File: rtl/adder_share_pkg.sv
// adder_share_pkg
//   Shared definitions for the adder time-sharing controller:
//   sequencer state encoding, operand widths and a saturating increment
//   helper used by the optional statistics counters.
package adder_share_pkg;

  localparam int HALF_W = 32;
  localparam int FULL_W = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    INC  = 3'd3,
    RESP = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at ptr and wraps
//   upward; the first asserted request wins.
//   Ports:
//     req       in  NREQ  request vector
//     ptr       in  IDW   highest-priority index for this arbitration
//     en        in  1     grant enable (grant forced to zero when low)
//     grant     out NREQ  one-hot grant (zero when en low or no request)
//     grant_idx out IDW   index of the winning request (valid when any)
//     any       out 1     at least one request asserted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the request closest to ptr
  // (offset 0 first) is the last one written and therefore wins.
  always_comb begin
    cand      = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (req[cand]) begin
        grant_idx = cand;
        any       = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (en && any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Time-shares one external combinational 32-bit adder (cin = 0) among
//   NREQ requesters. Narrow ops take one adder pass; wide (64-bit) ops take
//   three: low halves, high halves, then adding the low carry into the high
//   sum. One operation is in flight at a time.
//   Optional build macro: ADDER_SHARE_STATS_EN adds stat_ops / stat_wide.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid/ready/wide  per-requester handshake and width select
//     req_a, req_b          64 bits per requester, requester i at [64i+63:64i]
//     add_a, add_b          operands to the shared adder
//     add_s, add_cout       result from the shared adder
//     rsp_valid/ready       result handshake
//     rsp_id, rsp_sum, rsp_cout  result owner, 64-bit sum, full-width carry
//     stat_ops, stat_wide   (ADDER_SHARE_STATS_EN only) saturating counters
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic [HALF_W-1:0]    add_a,
  output logic [HALF_W-1:0]    add_b,
  input  logic [HALF_W-1:0]    add_s,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [FULL_W-1:0]    rsp_sum,
  output logic                 rsp_cout
`ifdef ADDER_SHARE_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_wide
`endif
);

  state_t state_reg, state_next;

  logic [IDW-1:0]    ptr_reg;
  logic [FULL_W-1:0] op_a_reg, op_b_reg;
  logic              wide_reg;
  logic [IDW-1:0]    id_reg;
  logic [HALF_W-1:0] sum_lo_reg, sum_hi_reg;
  logic              c_lo_reg, c_hi_reg, c_inc_reg;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic              accept;
  logic              rsp_fire;
  logic [IDW-1:0]    ptr_next;

  // Unpack the flat operand buses so the winner can be selected by index.
  logic [FULL_W-1:0] a_arr [NREQ];
  logic [FULL_W-1:0] b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[64*gi +: 64];
    assign b_arr[gi] = req_b[64*gi +: 64];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .en        (state_reg == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign accept   = (state_reg == IDLE) && grant_any;
  assign rsp_fire = (state_reg == RESP) && rsp_ready;
  assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LO;
      LO:      state_next = wide_reg ? HI : RESP;
      HI:      state_next = INC;
      INC:     state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE: req_ready = grant;
      LO: begin
        add_a = op_a_reg[HALF_W-1:0];
        add_b = op_b_reg[HALF_W-1:0];
      end
      HI: begin
        add_a = op_a_reg[FULL_W-1:HALF_W];
        add_b = op_b_reg[FULL_W-1:HALF_W];
      end
      INC: begin
        // Ripple the low-half carry into the high partial sum.
        add_a = sum_hi_reg;
        add_b = {{(HALF_W-1){1'b0}}, c_lo_reg};
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operation datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg    <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      wide_reg   <= 1'b0;
      id_reg     <= '0;
      sum_lo_reg <= '0;
      sum_hi_reg <= '0;
      c_lo_reg   <= 1'b0;
      c_hi_reg   <= 1'b0;
      c_inc_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg   <= a_arr[grant_idx];
            op_b_reg   <= b_arr[grant_idx];
            wide_reg   <= req_wide[grant_idx];
            id_reg     <= grant_idx;
            ptr_reg    <= ptr_next;
            // Narrow results must read zero in the upper half.
            sum_hi_reg <= '0;
            c_hi_reg   <= 1'b0;
            c_inc_reg  <= 1'b0;
          end
        end
        LO: begin
          sum_lo_reg <= add_s;
          c_lo_reg   <= add_cout;
        end
        HI: begin
          sum_hi_reg <= add_s;
          c_hi_reg   <= add_cout;
        end
        INC: begin
          sum_hi_reg <= add_s;
          c_inc_reg  <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_reg;
  assign rsp_sum  = {sum_hi_reg, sum_lo_reg};
  // At most one of c_hi / c_inc can be set: a high sum that carried out
  // cannot be all-ones, so the increment pass cannot carry again.
  assign rsp_cout = wide_reg ? (c_hi_reg | c_inc_reg) : c_lo_reg;

`ifdef ADDER_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_wide <= '0;
    end else if (rsp_fire) begin
      stat_ops <= sat_inc(stat_ops);
      if (wide_reg) begin
        stat_wide <= sat_inc(stat_wide);
      end
    end
  end
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready, req_wide;
  logic [64*NREQ-1:0]  req_a, req_b;
  logic [31:0]         add_a, add_b, add_s;
  logic                add_cout;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [63:0]         rsp_sum;
  logic                rsp_cout;
`ifdef ADDER_SHARE_STATS_EN
  logic [31:0]         stat_ops, stat_wide;
`endif

  always #5 clk = ~clk;

  // The shared adder lives outside the controller.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  adder_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wide  (req_wide),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_wide (stat_wide)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit              m_busy = 1'b0;
  int              m_cnt, m_lat, m_id;
  int              m_ptr = 0;
  bit              m_wide;
  logic [63:0]     m_a, m_b, m_sum;
  logic            m_cout;
  logic [64:0]     m_full;
  logic [32:0]     m_lo33, m_hi33;
  int              done_ops = 0, done_wide = 0;
  logic [NREQ-1:0] hs_last = '0;
  logic [NREQ-1:0] exp_ready;
  int              win;

  always @(negedge clk) begin
    hs_last = req_valid & req_ready;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_cout", rsp_cout, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      m_busy = 1'b0; m_ptr = 0; done_ops = 0; done_wide = 0;
    end else if (!m_busy) begin
      win = -1;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      chk("idle_req_ready", req_ready, exp_ready);
      chk("idle_add_a", add_a, 0);
      chk("idle_add_b", add_b, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      if (win >= 0) begin
        m_busy = 1'b1; m_cnt = 0; m_id = win;
        m_wide = req_wide[win];
        m_a = req_a[64*win +: 64];
        m_b = req_b[64*win +: 64];
        m_lo33 = {1'b0, m_a[31:0]} + {1'b0, m_b[31:0]};
        m_hi33 = {1'b0, m_a[63:32]} + {1'b0, m_b[63:32]};
        m_full = {1'b0, m_a} + {1'b0, m_b};
        if (m_wide) begin
          m_sum = m_full[63:0]; m_cout = m_full[64]; m_lat = 4;
        end else begin
          m_sum = {32'd0, m_lo33[31:0]}; m_cout = m_lo33[32]; m_lat = 2;
        end
        m_ptr = (win + 1) % NREQ;
      end
    end else begin
      m_cnt++;
      chk("busy_req_ready", req_ready, 0);
      if (m_cnt == 1) begin
        chk("lo_add_a", add_a, m_a[31:0]);
        chk("lo_add_b", add_b, m_b[31:0]);
      end
      if (m_wide && m_cnt == 2) begin
        chk("hi_add_a", add_a, m_a[63:32]);
        chk("hi_add_b", add_b, m_b[63:32]);
      end
      if (m_wide && m_cnt == 3) begin
        chk("inc_add_a", add_a, m_hi33[31:0]);
        chk("inc_add_b", add_b, {31'd0, m_lo33[32]});
      end
      if (m_cnt < m_lat) begin
        chk("early_rsp_valid", rsp_valid, 0);
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_cout", rsp_cout, m_cout);
        if (rsp_ready) begin
          m_busy = 1'b0;
          done_ops++;
          if (m_wide) done_wide++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] pick64();
    logic [63:0] v;
    case ($urandom % 4)
      0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      1:       v = {32'd0, 32'hFFFF_FFFF};
      2:       v = {$urandom, $urandom};
      default: v = {32'd0, $urandom};
    endcase
    return v;
  endfunction

  task automatic new_op(input int i);
    req_valid[i] = 1'b1;
    req_wide[i]  = 1'($urandom % 2);
    req_a[64*i +: 64] = pick64();
    req_b[64*i +: 64] = pick64();
  endtask

  task automatic set_op(input int i, input bit wide, input logic [63:0] a, input logic [63:0] b);
    req_valid[i] = 1'b1;
    req_wide[i]  = wide;
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
  endtask

  // Waits (bounded) for a handshake on requester i, seen at a negedge.
  task automatic wait_accept(input int i, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin ok = 1'b1; break; end
    end
    chk({nm, "_accept"}, ok, 1);
  endtask

  // One isolated op with literal expectations and latency measurement.
  task automatic do_single(input int i, input bit wide, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_sum,
                           input bit exp_cout, input int exp_lat, input string nm);
    int lat = 0;
    @(posedge clk); #1;
    set_op(i, wide, a, b);
    wait_accept(i, nm);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_sum"}, rsp_sum, exp_sum);
    chk({nm, "_cout"}, rsp_cout, exp_cout);
    chk({nm, "_id"}, rsp_id, i);
  endtask

  // ---------------- main sequence ----------------
  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [63:0] t5_a, t5_b;
  bit got;

  initial begin
    req_valid = '0; req_wide = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: narrow carry-out, wide with low carry, wide overflow.
    do_single(0, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'h0, 1'b1, 2, "t1");
    do_single(1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 4, "t2");
    do_single(2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 4, "t3");
    do_single(3, 1'b0, 64'h1234_5678_8000_0000, 64'h9999_9999_8000_0001, 64'h1, 1'b1, 2, "t3b");

    // All requesters valid continuously, pointer back at 0.
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    for (int g = 0; g < 5; g++) begin
      got = 1'b0;
      order[g] = -1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (|(req_valid & req_ready)) begin got = 1'b1; break; end
      end
      chk("t4_grant_seen", got, 1);
      for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) order[g] = i;
      @(posedge clk); #1;
      if (order[g] >= 0) new_op(order[g]);
    end
    req_valid = '0;
    for (int g = 0; g < 5; g++) chk($sformatf("t4_order%0d", g), order[g], exp_order[g]);
    repeat (8) @(posedge clk);

    // Back-pressure: result held 10 cycles while requester 2 waits.
    #1;
    rsp_ready = 1'b0;
    t5_a = {32'd0, $urandom};
    t5_b = {32'd0, $urandom};
    set_op(1, 1'b0, t5_a, t5_b);
    set_op(2, 1'b0, 64'd3, 64'd4);
    wait_accept(1, "t5");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("t5_rsp_seen", got, 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_sum", rsp_sum, {31'd0, {1'b0, t5_a[31:0]} + {1'b0, t5_b[31:0]}} & 64'hFFFF_FFFF);
      chk("t5_hold_id", rsp_id, 1);
      chk("t5_hold_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_hs_ready", req_ready, 0);
    @(negedge clk);
    chk("t5_next_accept", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (6) @(posedge clk);

    // Reset pulsed while a wide op sits in its high-half pass.
    #1;
    set_op(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_accept(1, "t6");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rsp_in_rst", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_op(0, 1'b0, 64'd5, 64'd7);
    set_op(3, 1'b0, 64'd1, 64'd1);
    @(negedge clk);
    chk("t6_ptr_reset", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("t6_rsp_seen", got, 1);
    chk("t6_sum", rsp_sum, 64'd12);
    chk("t6_id", rsp_id, 0);
    chk("t6_cout", rsp_cout, 0);
    wait_accept(3, "t6_r3");
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    repeat (6) @(posedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && hs_last[i]) begin
          if ($urandom % 2 == 0) new_op(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && ($urandom % 3 == 0)) begin
          new_op(i);
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", m_busy, 0);
`ifdef ADDER_SHARE_STATS_EN
    chk("stat_ops", stat_ops, done_ops);
    chk("stat_wide", stat_wide, done_wide);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycles=50000 limit=50000");
    $fatal(1, "timeout");
  end

endmodule
